regfile: RTL and testbench

//   General-purpose register file of the KGPMini RISC processor datapath.
//   Two asynchronous (combinational) read ports feed the ALU operands.
//   One synchronous write port takes the writeback result.
//   32 registers x 32 bits.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile.sv | 39 +++
 tb/tb_regfile.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the KGPMini register file.
// The CPU datapath imports this package to size its operand and writeback buses.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile.sv
// KGPMini general-purpose register file: 32 x 32 storage, two combinational
// read ports for the ALU operands and one clocked writeback port.
module regfile #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2
);

    localparam int NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NumRegs];

    // NOTE: every entry is cleared by the asynchronous reset, so the array is
    // built from resettable flops rather than a RAM macro; sequential state
    // uses non-blocking assignments so all readers see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite) begin
            regs[writeReg] <= writeData;
        end
    end

    // No write-to-read bypass: a same-index read shows the new value only after the edge.
    assign data1 = regs[readReg1];
    assign data2 = regs[readReg2];

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic compared against a plain array model of the register contents.
module tb_regfile;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    reg_addr_t readReg1;
    reg_addr_t readReg2;
    reg_addr_t writeReg;
    reg_data_t writeData;
    logic      RegWrite;
    reg_data_t data1;
    reg_data_t data2;

    int total = 0;
    int bad   = 0;

    // Expected architectural contents of every register.
    reg_data_t model [NUM_REGS];

    always #5 clk = ~clk;

    regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .readReg1 (readReg1),
        .readReg2 (readReg2),
        .writeReg (writeReg),
        .writeData(writeData),
        .RegWrite (RegWrite),
        .data1    (data1),
        .data2    (data2)
    );

    task automatic check(input string tag, input reg_data_t observed, input reg_data_t expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endtask

    // Drive both read addresses and compare against the model.
    task automatic readBoth(input reg_addr_t a1, input reg_addr_t a2, input string tag);
        readReg1 = a1;
        readReg2 = a2;
        #1;
        check({tag, "/data1"}, data1, model[a1]);
        check({tag, "/data2"}, data2, model[a2]);
    endtask

    // Hold a write for the given number of rising edges, then drop the enable.
    task automatic doWrite(input reg_addr_t addr, input reg_data_t value, input int cycles);
        @(negedge clk);
        writeReg  = addr;
        writeData = value;
        RegWrite  = 1'b1;
        repeat (cycles) @(posedge clk);
        model[addr] = value;
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        RegWrite  = 1'b0;
        readReg1  = '0;
        readReg2  = '0;
        writeReg  = '0;
        writeData = '0;
        clearModel();

        // Reset held for 10 ns, visible on the outputs while asserted.
        #1;
        check("in_reset/data1", data1, 32'd0);
        #9;
        reset = 1'b1;
        readBoth(5'd0, 5'd1, "reset_0_1");
        readBoth(5'd23, 5'd31, "reset_23_31");

        // Register 0 is an ordinary writable register.
        doWrite(5'd0, 32'd69, 2);
        readReg1 = 5'd0;
        readReg2 = 5'd23;
        #1;
        check("wr0/data1", data1, 32'd69);
        check("wr0/data2", data2, 32'd0);

        doWrite(5'd1, 32'd35, 1);
        readReg1 = 5'd0;
        readReg2 = 5'd1;
        #1;
        check("wr1/data1", data1, 32'd69);
        check("wr1/data2", data2, 32'd35);

        // Enable low: data on the write port must be ignored.
        @(negedge clk);
        RegWrite  = 1'b0;
        writeReg  = 5'd1;
        writeData = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        readReg1 = 5'd1;
        #1;
        check("we_low/reg1", data1, 32'd35);

        // Read-during-write: old value before the edge, new value after it.
        @(negedge clk);
        readReg1  = 5'd5;
        readReg2  = 5'd5;
        writeReg  = 5'd5;
        writeData = 32'hDEADBEEF;
        RegWrite  = 1'b1;
        #1;
        check("rdw_before/data1", data1, model[5]);
        check("rdw_before/data2", data2, model[5]);
        @(posedge clk);
        model[5] = 32'hDEADBEEF;
        #1;
        check("rdw_after/data1", data1, 32'hDEADBEEF);
        check("rdw_after/data2", data2, 32'hDEADBEEF);
        @(negedge clk);
        RegWrite = 1'b0;

        // Random traffic: reads checked both before and after each edge.
        for (int n = 0; n < 300; n++) begin
            reg_addr_t r1;
            reg_addr_t r2;
            reg_addr_t w;
            reg_data_t d;
            logic      we;
            @(negedge clk);
            r1 = reg_addr_t'($urandom_range(NUM_REGS - 1));
            r2 = (n % 7 == 0) ? r1 : reg_addr_t'($urandom_range(NUM_REGS - 1));
            w  = (n % 5 == 0) ? r1 : reg_addr_t'($urandom_range(NUM_REGS - 1));
            d  = reg_data_t'($urandom);
            we = 1'($urandom_range(1));
            readReg1  = r1;
            readReg2  = r2;
            writeReg  = w;
            writeData = d;
            RegWrite  = we;
            #1;
            check("rand_pre/data1", data1, model[r1]);
            check("rand_pre/data2", data2, model[r2]);
            @(posedge clk);
            if (we) model[w] = d;
            #1;
            check("rand_post/data1", data1, model[r1]);
            check("rand_post/data2", data2, model[r2]);
        end
        @(negedge clk);
        RegWrite = 1'b0;

        // Asynchronous reset between edges, overriding a write in progress.
        doWrite(5'd0, 32'h1111_1111, 1);
        doWrite(5'd1, 32'h2222_2222, 1);
        doWrite(5'd5, 32'h5555_5555, 1);
        readBoth(5'd0, 5'd5, "pre_reset");
        @(negedge clk);
        writeReg  = 5'd1;
        writeData = 32'd99;
        RegWrite  = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset/data1", data1, 32'd0);
        check("async_reset/data2", data2, 32'd0);
        @(posedge clk);
        #1;
        readReg1 = 5'd1;
        #1;
        check("reset_over_write/reg1", data1, 32'd0);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b1;
        clearModel();
        readBoth(5'd0, 5'd1, "post_reset_0_1");
        readBoth(5'd5, 5'd5, "post_reset_5_5");

        // Writes resume normally after reset release.
        doWrite(5'd31, 32'hCAFE_F00D, 1);
        readBoth(5'd31, 5'd5, "post_reset_wr31");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile
